// File: rtl/lab3_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// lab3_pkg : screen geometry, stream widths and sequencer state codes  (rev 1.0)
//------------------------------------------------------------------------------
package lab3_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int CNT_W    = 15;
    localparam int STATE_W  = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = 15'h7FFF;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_FILL_RUN  = 3'd1;
    localparam state_t ST_FILL_REL  = 3'd2;
    localparam state_t ST_SHAPE_RUN = 3'd3;
    localparam state_t ST_SHAPE_REL = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

endpackage
`default_nettype wire

// File: rtl/plot_clip.sv
`default_nettype none
//------------------------------------------------------------------------------
// plot_clip : combinational on-screen test for one pixel coordinate  (rev 1.0)
//------------------------------------------------------------------------------
module plot_clip
    import lab3_pkg::*;
(
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           on_screen
);

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    assign on_screen = (x <= X_MAX) && (y <= Y_MAX);

endmodule
`default_nettype wire

// File: rtl/plot_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// plot_sequencer : runs fill then shape engine, muxes and clips their plots  (rev 1.0)
//------------------------------------------------------------------------------
module plot_sequencer
    import lab3_pkg::*;
#(
    parameter bit CLEAR_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                fill_start,
    input  logic                fill_done,
    input  logic [X_W-1:0]      fill_x,
    input  logic [Y_W-1:0]      fill_y,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic                fill_plot,
    output logic                shape_start,
    input  logic                shape_done,
    input  logic [X_W-1:0]      shape_x,
    input  logic [Y_W-1:0]      shape_y,
    input  logic [COLOUR_W-1:0] shape_colour,
    input  logic                shape_plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic [CNT_W-1:0]    plot_count
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_done;
    logic                  r_fill_start;
    logic                  r_shape_start;
    logic [X_W-1:0]        r_vga_x;
    logic [Y_W-1:0]        r_vga_y;
    logic [COLOUR_W-1:0]   r_vga_colour;
    logic                  r_vga_plot;
    logic [CNT_W-1:0]      r_count;

    logic                  w_sel_fill;
    logic                  w_sel_shape;
    logic [X_W-1:0]        w_pix_x;
    logic [Y_W-1:0]        w_pix_y;
    logic [COLOUR_W-1:0]   w_pix_colour;
    logic                  w_pix_plot;
    logic                  w_on_screen;
    logic                  w_accept;
    logic                  w_seq_begin;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (start)       w_state_nxt = CLEAR_FIRST ? ST_FILL_RUN : ST_SHAPE_RUN;
            ST_FILL_RUN:  if (fill_done)   w_state_nxt = ST_FILL_REL;
            ST_FILL_REL:  if (!fill_done)  w_state_nxt = ST_SHAPE_RUN;
            ST_SHAPE_RUN: if (shape_done)  w_state_nxt = ST_SHAPE_REL;
            ST_SHAPE_REL: if (!shape_done) w_state_nxt = ST_DONE;
            ST_DONE:      if (!start)      w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so the engines see clean flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_fill_start  <= 1'b0;
            r_shape_start <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fill_start  <= (w_state_nxt == ST_FILL_RUN);
            r_shape_start <= (w_state_nxt == ST_SHAPE_RUN);
            r_done        <= (w_state_nxt == ST_DONE);
        end
    end

    assign w_sel_fill  = (r_state == ST_FILL_RUN);
    assign w_sel_shape = (r_state == ST_SHAPE_RUN);
    assign w_seq_begin = (r_state == ST_IDLE) && start;

    always_comb begin
        w_pix_x      = fill_x;
        w_pix_y      = fill_y;
        w_pix_colour = fill_colour;
        w_pix_plot   = 1'b0;
        if (w_sel_fill) begin
            w_pix_plot   = fill_plot;
        end else if (w_sel_shape) begin
            w_pix_x      = shape_x;
            w_pix_y      = shape_y;
            w_pix_colour = shape_colour;
            w_pix_plot   = shape_plot;
        end
    end

    plot_clip u_clip (
        .x         (w_pix_x),
        .y         (w_pix_y),
        .on_screen (w_on_screen)
    );

    assign w_accept = w_pix_plot && w_on_screen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_plot <= w_accept;
            if (w_sel_fill || w_sel_shape) begin
                r_vga_x      <= w_pix_x;
                r_vga_y      <= w_pix_y;
                r_vga_colour <= w_pix_colour;
            end
        end
    end

    // Count survives DONE/IDLE so the caller can read it after the sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_seq_begin) begin
            r_count <= '0;
        end else if (w_accept && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done        = r_done;
    assign fill_start  = r_fill_start;
    assign shape_start = r_shape_start;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;
    assign plot_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_plot_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_plot_sequencer : randomized engine models with pixel/handshake scoreboard  (rev 1.0)
//------------------------------------------------------------------------------
module tb_plot_sequencer;
    import lab3_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n, start, start0, shape_done0, fill_done0;
    logic       done, fill_start, shape_start, vga_plot;
    logic       done0, fill_start0, shape_start0, vga_plot0;
    logic       fill_done, fill_plot, shape_done, shape_plot;
    logic [7:0] fill_x, shape_x, vga_x, vga_x0;
    logic [6:0] fill_y, shape_y, vga_y, vga_y0;
    logic [2:0] fill_colour, shape_colour, vga_colour, vga_colour0;
    logic [14:0] plot_count, plot_count0;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    int         m_cnt;
    int         fill_n, fill_i, fill_hold, shape_hold;
    bit         ev_fill_drop, ev_shape_drop;
    pix_t       shp_q[$];

    always #5 clk = ~clk;

    plot_sequencer #(.CLEAR_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .fill_start(fill_start), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
        .shape_start(shape_start), .shape_done(shape_done),
        .shape_x(shape_x), .shape_y(shape_y), .shape_colour(shape_colour), .shape_plot(shape_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .plot_count(plot_count)
    );

    plot_sequencer #(.CLEAR_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .done(done0),
        .fill_start(fill_start0), .fill_done(fill_done0),
        .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
        .shape_start(shape_start0), .shape_done(shape_done0),
        .shape_x(shape_x), .shape_y(shape_y), .shape_colour(shape_colour), .shape_plot(shape_plot),
        .vga_x(vga_x0), .vga_y(vga_y0), .vga_colour(vga_colour0), .vga_plot(vga_plot0),
        .plot_count(plot_count0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit on_screen(input logic [7:0] x, input logic [6:0] y);
        return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    endfunction

    // One clock: predict from pre-edge inputs/handshakes, then compare after the edge.
    task automatic tick();
        logic pre_rst, pf, ps, pfd, psd, acc;
        pre_rst = rst_n;
        pf  = fill_start;
        ps  = shape_start;
        pfd = fill_done;
        psd = shape_done;
        acc = (pf && fill_plot && on_screen(fill_x, fill_y)) ||
              (ps && shape_plot && on_screen(shape_x, shape_y));
        if (!pre_rst) begin
            m_x = '0; m_y = '0; m_c = '0; m_cnt = 0;
        end else if (pf) begin
            m_x = fill_x; m_y = fill_y; m_c = fill_colour;
        end else if (ps) begin
            m_x = shape_x; m_y = shape_y; m_c = shape_colour;
        end
        if (pre_rst && acc && m_cnt < 32767) m_cnt++;
        @(posedge clk);
        #1;
        if (!pre_rst) begin
            check("rst_fill_start",  32'(fill_start), 0);
            check("rst_shape_start", 32'(shape_start), 0);
            check("rst_done",        32'(done), 0);
            check("rst_vga_xyc",     32'({vga_x, vga_y, vga_colour}), 0);
            check("rst_vga_plot",    32'(vga_plot), 0);
            check("rst_plot_count",  32'(plot_count), 0);
        end else begin
            check("start_overlap", 32'(fill_start & shape_start), 0);
            check("vga_plot",      32'(vga_plot), 32'(acc));
            check("vga_x",         32'(vga_x), 32'(m_x));
            check("vga_y",         32'(vga_y), 32'(m_y));
            check("vga_colour",    32'(vga_colour), 32'(m_c));
            check("plot_count",    32'(plot_count), 32'(m_cnt));
            if (pfd) begin
                check("fill_done_fs", 32'(fill_start), 0);
                check("fill_done_ss", 32'(shape_start), 0);
            end
            if (psd) begin
                check("shape_done_ss",   32'(shape_start), 0);
                check("shape_done_done", 32'(done), 0);
            end
            if (ev_fill_drop)  check("shape_after_fill_rel", 32'(shape_start), 1);
            if (ev_shape_drop) check("done_after_shape_rel", 32'(done), 1);
        end
        ev_fill_drop  = 1'b0;
        ev_shape_drop = 1'b0;
    endtask

    // Behavioural fill and shape engines; idle engines drive junk with plot high.
    task automatic drive_engines();
        pix_t p;
        if (fill_done) begin
            fill_plot = 1'($urandom); fill_x = 8'($urandom); fill_y = 7'($urandom); fill_colour = 3'($urandom);
            if (!fill_start) begin
                if (fill_hold > 0) fill_hold--;
                else begin fill_done = 1'b0; ev_fill_drop = 1'b1; end
            end
        end else if (fill_start && fill_i < fill_n) begin
            if ($urandom_range(0, 15) == 0) begin
                fill_plot = 1'b0; fill_x = 8'($urandom); fill_y = 7'($urandom);
            end else begin
                fill_x = 8'(fill_i / 120); fill_y = 7'(fill_i % 120);
                fill_colour = 3'd0; fill_plot = 1'b1; fill_i++;
            end
        end else if (fill_start) begin
            fill_done = 1'b1; fill_plot = 1'b0;
        end else begin
            fill_plot = 1'b1; fill_x = 8'($urandom_range(0, 159)); fill_y = 7'($urandom_range(0, 119));
            fill_colour = 3'($urandom);
        end

        if (shape_done) begin
            shape_plot = 1'($urandom); shape_x = 8'($urandom); shape_y = 7'($urandom);
            if (!shape_start) begin
                if (shape_hold > 0) shape_hold--;
                else begin shape_done = 1'b0; ev_shape_drop = 1'b1; end
            end
        end else if (shape_start && shp_q.size() > 0) begin
            if ($urandom_range(0, 15) == 0) begin
                shape_plot = 1'b0; shape_x = 8'($urandom); shape_y = 7'($urandom);
            end else begin
                p = shp_q.pop_front();
                shape_x = p.x; shape_y = p.y; shape_colour = p.c; shape_plot = 1'b1;
            end
        end else if (shape_start) begin
            shape_done = 1'b1; shape_plot = 1'b0;
        end else begin
            shape_plot = 1'b1; shape_x = 8'($urandom_range(0, 159)); shape_y = 7'($urandom_range(0, 119));
            shape_colour = 3'($urandom);
        end
    endtask

    task automatic engines_reset();
        fill_done = 1'b0; shape_done = 1'b0;
        fill_n = 0; fill_i = 0; fill_hold = 0; shape_hold = 0;
        shp_q.delete();
    endtask

    task automatic run_seq(input int fn, input int sn, input int fh, input int sh,
                           input bit on_only, input bit directed, input bit drop, input bit abort);
        int   cyc, shp_cyc, exp_total;
        pix_t p;
        fill_n = fn; fill_i = 0; fill_hold = fh; shape_hold = sh;
        shp_q.delete();
        exp_total = fn;
        if (directed) begin
            shp_q.push_back('{x: 8'd160, y: 7'd10,  c: 3'd5});
            shp_q.push_back('{x: 8'd10,  y: 7'd120, c: 3'd5});
            shp_q.push_back('{x: 8'd255, y: 7'd127, c: 3'd5});
            shp_q.push_back('{x: 8'd159, y: 7'd119, c: 3'd6});
            exp_total += 1;
        end
        for (int i = 0; i < sn; i++) begin
            p.x = on_only ? 8'($urandom_range(0, 159)) : 8'($urandom);
            p.y = on_only ? 7'($urandom_range(0, 119)) : 7'($urandom);
            p.c = 3'($urandom);
            shp_q.push_back(p);
            if (on_screen(p.x, p.y)) exp_total++;
        end
        if (exp_total > 32767) exp_total = 32767;

        m_cnt = 0;
        start = 1'b1;
        drive_engines();
        tick();
        check("start_to_fill_start", 32'(fill_start), 1);
        check("start_no_shape_start", 32'(shape_start), 0);

        cyc = 0;
        shp_cyc = 0;
        while (!done && cyc < 60000) begin
            if (drop) start = (cyc < 4 || cyc > 9);
            if (abort && shape_start) begin
                shp_cyc++;
                if (shp_cyc == 3) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    engines_reset();
                    tick();
                    rst_n = 1'b1;
                    drive_engines();
                    tick();
                    return;
                end
            end
            drive_engines();
            tick();
            cyc++;
        end
        check("seq_done", 32'(done), 1);
        check("seq_total", 32'(plot_count), 32'(exp_total));

        for (int k = 0; k < 3; k++) begin
            drive_engines();
            tick();
            check("done_held", 32'(done), 1);
            check("no_restart", 32'(fill_start | shape_start), 0);
        end
        start = 1'b0;
        drive_engines();
        tick();
        check("done_clear", 32'(done), 0);
        check("count_held", 32'(plot_count), 32'(exp_total));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; shape_done0 = 1'b0; fill_done0 = 1'b0;
        ev_fill_drop = 1'b0; ev_shape_drop = 1'b0;
        m_x = '0; m_y = '0; m_c = '0; m_cnt = 0;
        engines_reset();
        drive_engines();
        tick();
        drive_engines();
        tick();
        rst_n = 1'b1;
        drive_engines();
        tick();

        run_seq(19200, 50,    1, 1, 1'b1, 1'b0, 1'b0, 1'b0);  // full clear + 50 shape pixels
        run_seq(40,    0,     0, 0, 1'b0, 1'b1, 1'b0, 1'b0);  // clipping corners
        run_seq(300,   30,    5, 5, 1'b0, 1'b0, 1'b1, 1'b0);  // long REL holds, start glitch
        run_seq(100,   40,    0, 0, 1'b0, 1'b0, 1'b0, 1'b1);  // reset during shape phase
        run_seq(50,    20,    0, 2, 1'b0, 1'b0, 1'b0, 1'b0);  // rerun after reset
        run_seq(19200, 13600, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // counter saturation

        // shape-only variant
        start0 = 1'b1;
        drive_engines();
        tick();
        check("cf0_fill_start", 32'(fill_start0), 0);
        check("cf0_shape_start", 32'(shape_start0), 1);
        for (int k = 0; k < 4; k++) begin
            drive_engines();
            tick();
            check("cf0_fill_start_run", 32'(fill_start0), 0);
        end
        shape_done0 = 1'b1;
        drive_engines();
        tick();
        check("cf0_shape_start_off", 32'(shape_start0), 0);
        shape_done0 = 1'b0;
        drive_engines();
        tick();
        check("cf0_done", 32'(done0), 1);
        check("cf0_fill_never", 32'(fill_start0), 0);
        start0 = 1'b0;
        drive_engines();
        tick();
        check("cf0_done_clear", 32'(done0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
